// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone cycle-type constants and burst reader FSM encoding
package wb_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, WAIT_ACK} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy; head reads zero while empty
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;
    always_comb begin
        do_push  = push && (count_q != (AW+1)'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_in;
    end
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/wb_burst_reader.sv
// wb_burst_reader: Wishbone pipelined burst read master feeding a valid/ready stream
module wb_burst_reader
    import wb_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_SYNC_N,
    input  logic             START_IN,
    input  logic [31:0]      START_ADDR_IN,
    input  logic [CNT_W-1:0] WORD_COUNT_IN,
    output logic             BUSY_OUT,
    output logic             DONE_OUT,
    output logic             ERR_OUT,
    output logic [31:0]      WB_ADR_OUT,
    output logic             WB_CYC_OUT,
    output logic             WB_STB_OUT,
    output logic             WB_WE_OUT,
    output logic [3:0]       WB_SEL_OUT,
    output logic [2:0]       WB_CTI_OUT,
    output logic [1:0]       WB_BTE_OUT,
    input  logic             WB_ACK_IN,
    input  logic             WB_STALL_IN,
    input  logic             WB_ERR_IN,
    input  logic [31:0]      WB_DAT_RD_IN,
    output logic [31:0]      DATA_OUT,
    output logic             VALID_OUT,
    input  logic             READY_IN
);
    localparam int BL_W = $clog2(BURST_LEN) + 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    state_t           state_q, state_d;
    logic [31:0]      adr_q, adr_d;
    logic [2:0]       cti_q, cti_d;
    logic             cyc_q, cyc_d, stb_q, stb_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [BL_W-1:0]  blen_q, blen_d, issued_q, issued_d, acked_q, acked_d, blen;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty, ack_ok, pop;
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        cti_d    = cti_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        rem_d    = rem_q;
        blen_d   = blen_q;
        issued_d = issued_q;
        acked_d  = acked_q;
        blen     = (rem_q >= CNT_W'(BURST_LEN)) ? BL_W'(BURST_LEN) : BL_W'(rem_q);
        ack_ok   = cyc_q && WB_ACK_IN && !WB_ERR_IN;
        case (state_q)
            IDLE: if (START_IN) begin
                err_d = 1'b0;
                if (WORD_COUNT_IN == '0) done_d = 1'b1;
                else begin
                    adr_d   = START_ADDR_IN & 32'hFFFF_FFFC;
                    rem_d   = WORD_COUNT_IN;
                    busy_d  = 1'b1;
                    state_d = WAIT_SPACE;
                end
            end
            // a burst starts only once the FIFO can hold every word of it
            WAIT_SPACE: if (CW'(FIFO_DEPTH) - fifo_count >= CW'(blen)) begin
                state_d  = REQ;
                cyc_d    = 1'b1;
                stb_d    = 1'b1;
                blen_d   = blen;
                issued_d = '0;
                acked_d  = '0;
                cti_d    = (blen == BL_W'(1)) ? CTI_END : CTI_INCR;
            end
            REQ: if (!WB_STALL_IN) begin
                adr_d    = adr_q + 32'd4;
                issued_d = issued_q + 1'b1;
                if (issued_q == blen_q - 1'b1) begin
                    stb_d   = 1'b0;
                    state_d = WAIT_ACK;
                end else cti_d = (issued_q + BL_W'(2) == blen_q) ? CTI_END : CTI_INCR;
            end
            default: ;
        endcase
        if (ack_ok) begin
            acked_d = acked_q + 1'b1;
            if (acked_q + 1'b1 == blen_q) begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                rem_d   = rem_q - CNT_W'(blen_q);
                state_d = (rem_d != '0) ? WAIT_SPACE : IDLE;
                done_d  = (rem_d == '0);
                busy_d  = (rem_d != '0);
            end
        end
        // an error aborts the whole transfer; its data beat is dropped
        if (cyc_q && WB_ERR_IN) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST_SYNC_N) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            cti_q    <= CTI_CLASSIC;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rem_q    <= '0;
            blen_q   <= '0;
            issued_q <= '0;
            acked_q  <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            cti_q    <= cti_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rem_q    <= rem_d;
            blen_q   <= blen_d;
            issued_q <= issued_d;
            acked_q  <= acked_d;
        end
    end
    assign pop = VALID_OUT && READY_IN;
    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_SYNC_N),
        .push     (ack_ok),
        .pop      (pop),
        .data_in  (WB_DAT_RD_IN),
        .data_out (DATA_OUT),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );
    assign VALID_OUT  = !fifo_empty;
    assign BUSY_OUT   = busy_q;
    assign DONE_OUT   = done_q;
    assign ERR_OUT    = err_q;
    assign WB_ADR_OUT = adr_q;
    assign WB_CYC_OUT = cyc_q;
    assign WB_STB_OUT = stb_q;
    assign WB_WE_OUT  = 1'b0;
    assign WB_SEL_OUT = 4'hF;
    assign WB_CTI_OUT = cti_q;
    assign WB_BTE_OUT = BTE_LINEAR;
endmodule

// File: tb/tb_wb_burst_reader.sv
// tb_wb_burst_reader: directed scoreboard bench with a pipelined Wishbone slave model
module tb_wb_burst_reader;
    logic        CLK = 1'b0, RST_SYNC_N = 1'b0, START_IN = 1'b0, READY_IN = 1'b0;
    logic [31:0] START_ADDR_IN = '0;
    logic [15:0] WORD_COUNT_IN = '0;
    logic        BUSY_OUT, DONE_OUT, ERR_OUT, WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT, VALID_OUT;
    logic [31:0] WB_ADR_OUT, DATA_OUT;
    logic [3:0]  WB_SEL_OUT;
    logic [2:0]  WB_CTI_OUT;
    logic [1:0]  WB_BTE_OUT;
    logic        WB_ACK_IN = 1'b0, WB_STALL_IN = 1'b0, WB_ERR_IN = 1'b0;
    logic [31:0] WB_DAT_RD_IN = '0;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    logic        stall_en = 1'b0, cyc_prev = 1'b0, prev_hold = 1'b0;
    int          err_at = 0, ack_idx = 0, m_rem = 0, m_beat = 0, m_blen = 0;
    int          n_acc = 0, n_pop = 0, n_bursts = 0, n_done = 0;
    logic [31:0] exp_adr = '0, prev_adr = '0;
    logic [2:0]  prev_cti = '0;

    always #5 CLK = ~CLK;

    wb_burst_reader dut (
        .CLK(CLK), .RST_SYNC_N(RST_SYNC_N), .START_IN(START_IN), .START_ADDR_IN(START_ADDR_IN),
        .WORD_COUNT_IN(WORD_COUNT_IN), .BUSY_OUT(BUSY_OUT), .DONE_OUT(DONE_OUT), .ERR_OUT(ERR_OUT),
        .WB_ADR_OUT(WB_ADR_OUT), .WB_CYC_OUT(WB_CYC_OUT), .WB_STB_OUT(WB_STB_OUT), .WB_WE_OUT(WB_WE_OUT),
        .WB_SEL_OUT(WB_SEL_OUT), .WB_CTI_OUT(WB_CTI_OUT), .WB_BTE_OUT(WB_BTE_OUT), .WB_ACK_IN(WB_ACK_IN),
        .WB_STALL_IN(WB_STALL_IN), .WB_ERR_IN(WB_ERR_IN), .WB_DAT_RD_IN(WB_DAT_RD_IN),
        .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT), .READY_IN(READY_IN)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Slave: drives responses for the coming edge; acks one cycle or more after acceptance.
    always @(negedge CLK) begin
        WB_STALL_IN = stall_en ? 1'($urandom_range(1)) : 1'b0;
        WB_ACK_IN = 1'b0;
        WB_ERR_IN = 1'b0;
        if (!WB_CYC_OUT || !RST_SYNC_N) pend_q.delete();
        else if (pend_q.size() > 0) begin
            ack_idx++;
            if (ack_idx == err_at) begin
                WB_ERR_IN = 1'b1;
                pend_q.delete();
            end else begin
                WB_ACK_IN = 1'b1;
                WB_DAT_RD_IN = mem_word(pend_q.pop_front());
                exp_q.push_back(WB_DAT_RD_IN);
            end
        end
        if (RST_SYNC_N && WB_CYC_OUT && WB_STB_OUT) begin
            if (prev_hold) begin
                chk("adr_hold", WB_ADR_OUT, prev_adr);
                chk("cti_hold", 32'(WB_CTI_OUT), 32'(prev_cti));
            end
            prev_hold = WB_STALL_IN;
            prev_adr = WB_ADR_OUT;
            prev_cti = WB_CTI_OUT;
            if (!WB_STALL_IN) begin
                if (m_beat == 0) m_blen = (m_rem < 8) ? m_rem : 8;
                chk("beat_adr", WB_ADR_OUT, exp_adr);
                chk("beat_cti", 32'(WB_CTI_OUT), (m_beat == m_blen - 1) ? 32'h7 : 32'h2);
                pend_q.push_back(WB_ADR_OUT);
                exp_adr += 32'd4;
                n_acc++;
                m_beat++;
                if (m_beat == m_blen) begin
                    m_beat = 0;
                    m_rem -= m_blen;
                end
            end
        end else prev_hold = 1'b0;
    end

    // Monitor: the word on DATA_OUT is consumed at the coming edge when VALID && READY.
    always @(negedge CLK) begin
        if (RST_SYNC_N && VALID_OUT && READY_IN) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_extra: got %h expected no word", DATA_OUT);
            end else chk("data", DATA_OUT, exp_q.pop_front());
        end
        if (DONE_OUT) n_done++;
        if (WB_CYC_OUT && !cyc_prev) n_bursts++;
        cyc_prev = WB_CYC_OUT;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [31:0] addr, input logic [15:0] cnt);
        exp_adr = addr & 32'hFFFF_FFFC;
        m_rem = int'(cnt);
        m_beat = 0;
        n_acc = 0;
        n_pop = 0;
        n_bursts = 0;
        n_done = 0;
        ack_idx = 0;
        START_ADDR_IN = addr;
        WORD_COUNT_IN = cnt;
        START_IN = 1'b1;
        tick(1);
        START_IN = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int i = 0; i < limit && !DONE_OUT; i++) tick(1);
        chk(name, 32'(DONE_OUT), 32'd1);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (exp_q.size() != 0 || VALID_OUT); i++) tick(1);
        chk("drain_scoreboard", exp_q.size(), 0);
        chk("drain_valid", 32'(VALID_OUT), 32'd0);
    endtask

    initial begin
        tick(3);
        chk("rst_cyc", 32'(WB_CYC_OUT), 0);
        chk("rst_stb", 32'(WB_STB_OUT), 0);
        chk("rst_busy", 32'(BUSY_OUT), 0);
        chk("rst_done", 32'(DONE_OUT), 0);
        chk("rst_err", 32'(ERR_OUT), 0);
        chk("rst_valid", 32'(VALID_OUT), 0);
        chk("rst_adr", WB_ADR_OUT, 0);
        chk("rst_cti", 32'(WB_CTI_OUT), 0);
        chk("rst_data", DATA_OUT, 0);
        chk("tie_we", 32'(WB_WE_OUT), 0);
        chk("tie_sel", 32'(WB_SEL_OUT), 32'hF);
        chk("tie_bte", 32'(WB_BTE_OUT), 0);
        RST_SYNC_N = 1'b1;
        READY_IN = 1'b1;
        tick(2);
        start(32'h100, 8);
        chk("single_busy", 32'(BUSY_OUT), 1);
        wait_done("single_done", 200);
        chk("single_busy_end", 32'(BUSY_OUT), 0);
        drain(100);
        chk("single_beats", n_acc, 8);
        chk("single_words", n_pop, 8);
        chk("single_bursts", n_bursts, 1);
        chk("single_done_cnt", n_done, 1);
        start(32'h2000, 20);
        wait_done("multi_done", 400);
        drain(100);
        chk("multi_beats", n_acc, 20);
        chk("multi_words", n_pop, 20);
        chk("multi_bursts", n_bursts, 3);
        READY_IN = 1'b0;
        start(32'h4000, 64);
        tick(300);
        chk("bp_beats", n_acc, 32);
        chk("bp_bursts", n_bursts, 4);
        chk("bp_cyc_idle", 32'(WB_CYC_OUT), 0);
        chk("bp_busy", 32'(BUSY_OUT), 1);
        READY_IN = 1'b1;
        wait_done("bp_done", 2000);
        drain(200);
        chk("bp_beats_all", n_acc, 64);
        chk("bp_words", n_pop, 64);
        stall_en = 1'b1;
        start(32'h8000, 20);
        wait_done("stall_done", 2000);
        drain(200);
        stall_en = 1'b0;
        chk("stall_beats", n_acc, 20);
        chk("stall_words", n_pop, 20);
        READY_IN = 1'b0;
        err_at = 3;
        start(32'hA000, 8);
        wait_done("err_done", 200);
        chk("err_cyc", 32'(WB_CYC_OUT), 0);
        chk("err_flag", 32'(ERR_OUT), 1);
        chk("err_busy", 32'(BUSY_OUT), 0);
        err_at = 0;
        tick(5);
        chk("err_flag_sticky", 32'(ERR_OUT), 1);
        chk("err_cyc_idle", 32'(WB_CYC_OUT), 0);
        READY_IN = 1'b1;
        drain(100);
        chk("err_words", n_pop, 2);
        start(32'h0, 0);
        chk("zero_done", 32'(DONE_OUT), 1);
        chk("zero_err_clr", 32'(ERR_OUT), 0);
        chk("zero_cyc", 32'(WB_CYC_OUT), 0);
        tick(1);
        chk("zero_done_pulse", 32'(DONE_OUT), 0);
        tick(4);
        chk("zero_bursts", n_bursts, 0);
        start(32'hFFFF_FFF8, 4);
        wait_done("wrap_done", 200);
        drain(100);
        chk("wrap_beats", n_acc, 4);
        chk("wrap_next_adr", WB_ADR_OUT, 32'h8);
        chk("wrap_words", n_pop, 4);
        READY_IN = 1'b0;
        start(32'h3000, 16);
        for (int i = 0; i < 200 && n_acc < 3; i++) tick(1);
        chk("midrst_started", 32'(n_acc >= 3), 1);
        RST_SYNC_N = 1'b0;
        tick(1);
        chk("midrst_cyc", 32'(WB_CYC_OUT), 0);
        chk("midrst_stb", 32'(WB_STB_OUT), 0);
        chk("midrst_valid", 32'(VALID_OUT), 0);
        chk("midrst_busy", 32'(BUSY_OUT), 0);
        exp_q.delete();
        RST_SYNC_N = 1'b1;
        READY_IN = 1'b1;
        tick(5);
        chk("midrst_quiet", 32'(VALID_OUT), 0);
        start(32'h500, 4);
        wait_done("post_rst_done", 200);
        drain(100);
        chk("post_rst_words", n_pop, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
